// File: rtl/ttt_pkg.sv
// ttt_pkg: cell codes, line table and FSM state type shared by the computer player
package ttt_pkg;
    localparam int NUM_CELLS = 9;
    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;
    localparam logic [1:0] CELL_OCC    = 2'b11;
    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };
    typedef enum logic [2:0] {IDLE, WIN, BLOCK, CENTER, FIRST, ISSUE} state_t;
endpackage

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: flags a line holding two cells of one side plus one empty cell
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic [1:0] c_i,
    input  logic [1:0] side_i,
    output logic       hit_o,
    output logic [1:0] slot_o
);
    logic [1:0] n_side, n_empty;
    always_comb begin
        n_side  = 2'(a_i == side_i) + 2'(b_i == side_i) + 2'(c_i == side_i);
        n_empty = 2'(a_i == CELL_EMPTY) + 2'(b_i == CELL_EMPTY) + 2'(c_i == CELL_EMPTY);
        hit_o   = (n_side == 2'd2) && (n_empty == 2'd1);
        slot_o  = a_i == CELL_EMPTY ? 2'd0 : b_i == CELL_EMPTY ? 2'd1 : 2'd2;
    end
endmodule

// File: rtl/ttt_computer_player.sv
// ttt_computer_player: sequential win/block/center/first-free move chooser for tic-tac-toe
module ttt_computer_player
    import ttt_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic [1:0] who,
    input  logic       move_req,
    output logic [3:0] computer_position,
    output logic       pc,
    output logic       busy,
    output logic       no_move
);
    state_t                        state_q;
    logic [NUM_CELLS-1:0][1:0]     board_q;
    logic [2:0]                    line_q;
    logic [3:0]                    cell_q;
    logic [3:0]                    pos_q;
    logic                          pc_q, busy_q, no_move_q;
    logic                          hit;
    logic [1:0]                    slot;

    // one evaluator serves both scans; the side code selects which owner is counted
    ttt_line_eval u_eval (
        .a_i    (board_q[LINES[line_q][0]]),
        .b_i    (board_q[LINES[line_q][1]]),
        .c_i    (board_q[LINES[line_q][2]]),
        .side_i (state_q == WIN ? CELL_COMP : CELL_PLAYER),
        .hit_o  (hit),
        .slot_o (slot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            board_q   <= '0;
            line_q    <= '0;
            cell_q    <= '0;
            pos_q     <= '0;
            pc_q      <= 1'b0;
            busy_q    <= 1'b0;
            no_move_q <= 1'b0;
        end else begin
            pc_q      <= 1'b0;
            no_move_q <= 1'b0;
            case (state_q)
                IDLE: if (move_req && who == 2'b00) begin
                    board_q <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
                    line_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= WIN;
                end
                WIN, BLOCK: if (hit) begin
                    pos_q   <= LINES[line_q][slot];
                    pc_q    <= 1'b1;
                    state_q <= ISSUE;
                end else begin
                    line_q <= line_q + 3'd1;
                    if (line_q == 3'd7) state_q <= state_q == WIN ? BLOCK : CENTER;
                end
                CENTER: if (board_q[4] == CELL_EMPTY) begin
                    pos_q   <= 4'd4;
                    pc_q    <= 1'b1;
                    state_q <= ISSUE;
                end else begin
                    cell_q  <= '0;
                    state_q <= FIRST;
                end
                FIRST: if (board_q[cell_q] == CELL_EMPTY) begin
                    pos_q   <= cell_q;
                    pc_q    <= 1'b1;
                    state_q <= ISSUE;
                end else if (cell_q == 4'(NUM_CELLS - 1)) begin
                    no_move_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end else begin
                    cell_q <= cell_q + 4'd1;
                end
                ISSUE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign computer_position = pos_q;
    assign pc                = pc_q;
    assign busy              = busy_q;
    assign no_move           = no_move_q;
endmodule

// File: tb/tb_ttt_computer_player.sv
// tb_ttt_computer_player: scoreboard bench for move choice, latency and reset behaviour
module tb_ttt_computer_player;
    localparam logic [1:0] E = 2'b00, P = 2'b01, C = 2'b10, O = 2'b11;

    typedef struct {
        int         cyc;
        logic       nm;
        logic [3:0] pos;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who;
    logic       move_req;
    logic [3:0] computer_position;
    logic       pc, busy, no_move;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    ttt_computer_player dut (
        .clock             (clock),
        .reset             (reset),
        .pos1              (pos1),
        .pos2              (pos2),
        .pos3              (pos3),
        .pos4              (pos4),
        .pos5              (pos5),
        .pos6              (pos6),
        .pos7              (pos7),
        .pos8              (pos8),
        .pos9              (pos9),
        .who               (who),
        .move_req          (move_req),
        .computer_position (computer_position),
        .pc                (pc),
        .busy              (busy),
        .no_move           (no_move)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) if (reset === 1'b0 && (pc || no_move)) chk("excl", 32'(pc & no_move), 32'd0);

    task automatic set_board(input logic [1:0] c [9]);
        {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} =
            {c[8], c[7], c[6], c[5], c[4], c[3], c[2], c[1], c[0]};
    endtask

    task automatic do_move(input string tag, input logic [1:0] c [9], input int exp_cyc,
                           input logic exp_nm, input logic [3:0] exp_pos, input int extra);
        exp_t e;
        int   cyc;
        logic got;
        sb.push_back('{exp_cyc, exp_nm, exp_pos});
        set_board(c);
        who = 2'b00;
        move_req = 1'b1;
        @(posedge clock); #1;
        move_req = 1'b0;
        set_board('{O, O, O, O, O, O, O, O, O});
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clock);
            if (pc || no_move) got = 1'b1;
            else begin
                @(posedge clock); #1;
                cyc++;
                move_req = (cyc == extra);
            end
        end
        move_req = 1'b0;
        e = sb.pop_front();
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
            chk({tag, "_nm"}, 32'(no_move), 32'(e.nm));
            chk({tag, "_pc"}, 32'(pc), 32'(!e.nm));
            if (!e.nm) chk({tag, "_pos"}, 32'(computer_position), 32'(e.pos));
        end
        @(posedge clock); #1;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_pulse"}, 32'(pc | no_move), 32'd0);
        if (!e.nm) chk({tag, "_hold"}, 32'(computer_position), 32'(e.pos));
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        move_req = 1'b0;
        who = 2'b00;
        set_board('{E, E, E, E, E, E, E, E, E});
        repeat (2) @(posedge clock); #1;
        chk("rst_pos", 32'(computer_position), 32'd0);
        chk("rst_flags", 32'({pc, busy, no_move}), 32'd0);
        reset = 1'b0;

        who = 2'b01;
        move_req = 1'b1;
        @(posedge clock); #1;
        move_req = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            seen |= pc | busy | no_move;
        end
        chk("who_ignored", 32'(seen), 32'd0);
        @(posedge clock); #1;

        do_move("win",    '{C, C, E, E, E, E, E, E, E}, 2,  1'b0, 4'd2, 0);
        do_move("block",  '{C, E, E, P, P, E, E, E, E}, 11, 1'b0, 4'd5, 5);
        do_move("center", '{E, E, E, E, E, E, E, E, E}, 18, 1'b0, 4'd4, 0);
        do_move("first0", '{E, E, E, E, P, E, E, E, E}, 19, 1'b0, 4'd0, 0);
        do_move("first5", '{P, C, P, O, O, E, E, E, E}, 24, 1'b0, 4'd5, 0);
        do_move("occ11",  '{C, O, C, E, E, E, C, C, E}, 4,  1'b0, 4'd8, 0);
        do_move("winpri", '{P, P, E, E, E, E, C, C, E}, 4,  1'b0, 4'd8, 0);
        do_move("full",   '{P, C, P, P, C, C, C, P, P}, 27, 1'b1, 4'd0, 0);

        set_board('{E, E, E, E, E, E, E, E, E});
        who = 2'b00;
        move_req = 1'b1;
        @(posedge clock); #1;
        move_req = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_idle", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            seen |= pc | no_move | busy;
        end
        chk("mid_quiet", 32'(seen), 32'd0);
        chk("mid_pos", 32'(computer_position), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ttt_computer_player.md
TTT_COMPUTER_PLAYER -- requirements
Module: ttt_computer_player

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports pos1..pos9, input, 2 bits each: board cells as driven by tic_tac_toe_game. Encoding: 00 empty, 01 player, 10 computer, 11 occupied/neither.
REQ-004 SHALL have port who, input, 2 bits: game result from tic_tac_toe_game. Value 00 means the game is in progress.
REQ-005 SHALL have port move_req, input, 1 bit: one-cycle request for a computer move.
REQ-006 SHALL have port computer_position, output, 4 bits: chosen cell index 0..8, where index n maps to pos(n+1).
REQ-007 SHALL have port pc, output, 1 bit: one-cycle strobe; computer_position is valid while pc is high.
REQ-008 SHALL have port busy, output, 1 bit: high from request accept until pc or no_move.
REQ-009 SHALL have port no_move, output, 1 bit: one-cycle pulse when no empty cell exists.

Function
REQ-010 SHALL use FSM states IDLE, WIN, BLOCK, CENTER, FIRST and ISSUE.
REQ-011 SHALL, in IDLE with move_req=1 and who=00, snapshot pos1..pos9 into a board register, set busy and enter WIN at line 0; call this cycle 0.
REQ-012 SHALL ignore move_req when who!=00 or when not in IDLE: no state change and no pulse.
REQ-013 SHALL evaluate the snapshot only; input changes while busy have no effect.
REQ-014 SHALL use line order 0..7: (0,1,2) (3,4,5) (6,7,8) (0,3,6) (1,4,7) (2,5,8) (0,4,8) (2,4,6).
REQ-015 SHALL, in WIN, evaluate one line per cycle; line k is evaluated in cycle k+1.
REQ-016 SHALL define a WIN hit as exactly two cells =10 and the third =00; on a hit the empty cell is chosen and the FSM goes to ISSUE.
REQ-017 SHALL, after WIN line 7 misses, scan BLOCK with the same line order; line k is evaluated in cycle k+9.
REQ-018 SHALL define a BLOCK hit as two cells =01 and the third =00; on a hit the empty cell is chosen.
REQ-019 SHALL, in CENTER (cycle 17), choose cell 4 if it is 00, else go to FIRST.
REQ-020 SHALL, in FIRST, evaluate cell c in cycle 18+c and choose the first cell equal to 00.
REQ-021 SHALL, in ISSUE, drive pc=1 for one cycle with computer_position set to the choice; the FSM then returns to IDLE and busy falls.
REQ-022 SHALL, if FIRST finds no 00 through cell 8, pulse no_move in cycle 27, never assert pc, and return to IDLE.
REQ-023 SHALL produce pc in these cycles: WIN line k at k+2; BLOCK line k at k+10; CENTER at 18; FIRST cell c at 19+c.
REQ-024 SHALL hold computer_position at its last issued value until the next ISSUE.
REQ-025 SHALL treat code 11 as occupied; it never contributes to a WIN or BLOCK count.
REQ-026 SHALL never have pc and no_move high in the same cycle.

Reset
REQ-027 SHALL, with reset high at a clock edge, force IDLE, computer_position=0, pc=0, busy=0, no_move=0 and board snapshot=all 00.
REQ-028 SHALL let reset abort any scan in progress; no pc or no_move follows the aborted request.

Structure
REQ-029 SHALL place the following in shared package ttt_pkg: cell encoding constants, the line table (8x3 indices), the state enum and NUM_CELLS=9.
REQ-030 SHALL use combinational sub-module ttt_line_eval. Inputs: three cells and a side code. Outputs: hit and the empty-slot offset 0..2. It is instantiated once and reused for WIN and BLOCK.

Verification
REQ-031 SHALL cover reset: after reset all outputs are 0; move_req with who=01 gives no pc and busy stays 0.
REQ-032 SHALL cover WIN: pos1=pos2=10, others 00 -> pc in cycle 2, computer_position=2.
REQ-033 SHALL cover BLOCK: pos4=pos5=01, pos1=10, rest 00 -> pc in cycle 11, computer_position=5.
REQ-034 SHALL cover CENTER and FIRST: an empty board gives pc in cycle 18 with position 4. pos5=01 with the rest empty gives pc in cycle 19 with position 0.
REQ-035 SHALL cover full board: cells 01/10 with no lines -> no_move in cycle 27 and pc never asserted.
REQ-036 SHALL cover reset mid-operation: reset asserted in cycle 12 of a request -> IDLE next cycle and no pc. A move_req asserted while busy is ignored.
